// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: shares a single multi-cycle Vedic multiplier among NREQ
// requesters. Round-robin grant, one operation in flight, operands and result
// latched, per-operation timeout watchdog.
//
// Handshakes:
//   request  : requester i holds req_valid[i] with stable operands; the
//              transfer happens in the cycle req_ready[i] is high (IDLE only,
//              one-hot, combinational from req_valid and the rr pointer).
//   response : rsp_valid/rsp_id/rsp_result/rsp_err hold stable until the
//              cycle rsp_valid & rsp_ready, which is the transfer.
//   multiplier: mul_a/mul_b are stable while mul_do is high; the first cycle
//              with mul_do & mul_done ends the operation. mul_done outside
//              WAIT is stale and ignored.
module vedic_mul_arbiter #(
  parameter  int W       = 8,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_result,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_do,
  input  logic [2*W-1:0]    mul_result,
  input  logic              mul_done,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [2*W-1:0]   rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             mul_do_q, mul_do_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  int               cand;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Next-state and datapath updates for the operation sequencer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_do_d     = mul_do_q;
    timer_d      = timer_q;
    req_ready    = '0;
    unique case (state_q)
      S_IDLE: begin
        // Ready stays low while reset is held so outputs read as zero.
        if (grant_found && reset) begin
          req_ready[grant_idx] = 1'b1;
          mul_a_d  = req_a[grant_idx*W +: W];
          mul_b_d  = req_b[grant_idx*W +: W];
          rsp_id_d = grant_idx;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_do_d = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (mul_done) begin
          rsp_result_d = mul_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          mul_do_d     = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          mul_do_d     = 1'b0;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (int'(rsp_id_q) == NREQ - 1) ? '0 : rsp_id_q + 1'b1;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        // One idle cycle so the multiplier can drop a lingering done.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_do_q     <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_do_q     <= mul_do_d;
      timer_q      <= timer_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_do     = mul_do_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule
